// File: rtl/seqdiv_pkg.sv
// Shared definitions for the sequential divider: op encoding, FSM states, iteration count.
package p_hardisc;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    localparam logic [1:0] SD_IDLE = 2'b00;
    localparam logic [1:0] SD_CALC = 2'b01;
    localparam logic [1:0] SD_DONE = 2'b10;

    localparam int unsigned DIV_ITER = 32;

endpackage

// File: rtl/seqdiv_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the divisor if it fits.
module seqdiv_step (
    input  logic [31:0] rem,
    input  logic        dvd_msb,
    input  logic [31:0] dvs,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] trial;
    logic [32:0] diff;

    // Partial remainder is always below the divisor, so a 33-bit trial is enough.
    assign trial    = {rem, dvd_msb};
    assign diff     = trial - {1'b0, dvs};
    assign q_bit    = (trial >= {1'b0, dvs});
    assign rem_next = q_bit ? diff[31:0] : trial[31:0];

endmodule

// File: rtl/seqdiv.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with EX/MA handshake.
module seqdiv
    import p_hardisc::*;
#(
    parameter bit P_FAST_SPECIAL = 1'b1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_stall_i,
    input  logic        s_flush_i,
    input  logic        s_compute_i,
    input  logic [1:0]  s_op_i,
    input  logic [31:0] s_operand1_i,
    input  logic [31:0] s_operand2_i,
    output logic        s_finished_o,
    output logic [31:0] s_result_o
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        sign_q_q, sign_q_d;
    logic        sign_r_q, sign_r_d;
    logic        is_rem_q, is_rem_d;
    logic        special_q, special_d;
    logic [31:0] forced_q, forced_d;
    logic [31:0] result_q, result_d;

    logic [31:0] rem_next;
    logic        q_bit;

    logic        is_signed;
    logic        neg1, neg2;
    logic [31:0] mag1, mag2;
    logic        div_zero, ovf;
    logic [31:0] quot_fin;

    seqdiv_step u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[31]),
        .dvs      (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign is_signed = ~s_op_i[0];
    assign neg1      = is_signed & s_operand1_i[31];
    assign neg2      = is_signed & s_operand2_i[31];
    assign mag1      = neg1 ? (~s_operand1_i + 32'd1) : s_operand1_i;
    assign mag2      = neg2 ? (~s_operand2_i + 32'd1) : s_operand2_i;
    assign div_zero  = (s_operand2_i == 32'd0);
    assign ovf       = is_signed & (s_operand1_i == 32'h8000_0000) &
                       (s_operand2_i == 32'hFFFF_FFFF);

    // Quotient bits are shifted into the vacated dividend LSBs.
    assign quot_fin  = {dvd_q[30:0], q_bit};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        is_rem_d  = is_rem_q;
        special_d = special_q;
        forced_d  = forced_q;
        result_d  = result_q;

        case (state_q)
            SD_IDLE: begin
                if (s_compute_i) begin
                    state_d   = SD_CALC;
                    dvd_d     = mag1;
                    dvs_d     = mag2;
                    rem_d     = 32'd0;
                    sign_q_d  = neg1 ^ neg2;
                    sign_r_d  = neg1;
                    is_rem_d  = s_op_i[1];
                    special_d = div_zero | ovf;
                    if (div_zero) begin
                        forced_d = s_op_i[1] ? s_operand1_i : 32'hFFFF_FFFF;
                    end else begin
                        forced_d = s_op_i[1] ? 32'd0 : 32'h8000_0000;
                    end
                    cnt_d = ((div_zero | ovf) && P_FAST_SPECIAL) ? 5'd0 : 5'(DIV_ITER - 1);
                end
            end
            SD_CALC: begin
                dvd_d = quot_fin;
                rem_d = rem_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = SD_DONE;
                    cnt_d   = 5'd0;
                    if (special_q) begin
                        result_d = forced_q;
                    end else if (is_rem_q) begin
                        result_d = sign_r_q ? (~rem_next + 32'd1) : rem_next;
                    end else begin
                        result_d = sign_q_q ? (~quot_fin + 32'd1) : quot_fin;
                    end
                end
            end
            SD_DONE: begin
                if (!s_stall_i) begin
                    state_d = SD_IDLE;
                end
            end
            default: state_d = SD_IDLE;
        endcase

        // Flush wins over acceptance, iteration and result writeback.
        if (s_flush_i) begin
            state_d  = SD_IDLE;
            cnt_d    = 5'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q   <= SD_IDLE;
            cnt_q     <= 5'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_q     <= 32'd0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            special_q <= 1'b0;
            forced_q  <= 32'd0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            is_rem_q  <= is_rem_d;
            special_q <= special_d;
            forced_q  <= forced_d;
            result_q  <= result_d;
        end
    end

    assign s_finished_o = (state_q == SD_DONE);
    assign s_result_o   = result_q;

endmodule

// File: tb/tb_seqdiv.sv
// Scoreboard bench for seqdiv: random and directed RV32M divides against an arithmetic model.
module tb_seqdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        compute = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        fin;
    logic [31:0] res;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
        int unsigned start;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_fin = 1'b0;

    seqdiv #(
        .P_FAST_SPECIAL (1'b1)
    ) dut (
        .s_clk_i      (clk),
        .s_resetn_i   (rst_n),
        .s_stall_i    (stall),
        .s_flush_i    (flush),
        .s_compute_i  (compute),
        .s_op_i       (op),
        .s_operand1_i (opa),
        .s_operand2_i (opb),
        .s_finished_o (fin),
        .s_result_o   (res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int unsigned ref_lat(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per rising edge of the finished flag.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin = 1'b0;
        end else begin
            if (fin && !prev_fin) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_finish: got result 0x%08h expected no finish", res);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (res !== mon_e.res) begin
                        errors++;
                        $display("FAIL result: got 0x%08h expected 0x%08h", res, mon_e.res);
                    end
                    checks++;
                    if (cyc - mon_e.start != mon_e.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d expected %0d", cyc - mon_e.start, mon_e.lat);
                    end
                end
            end
            prev_fin = fin;
        end
    end

    // Caller is at a negedge; the request is accepted on the following posedge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int stall_n, input bit scramble);
        exp_t        e;
        logic [31:0] exp_res;
        int          n;
        exp_res = ref_model(o, a, b);
        e.res   = exp_res;
        e.lat   = ref_lat(o, a, b);
        e.start = cyc;
        sb_q.push_back(e);
        compute = 1'b1;
        op      = o;
        opa     = a;
        opb     = b;
        @(negedge clk);
        if (scramble) begin
            op  = 2'($urandom);
            opa = $urandom;
            opb = $urandom;
            if ($urandom_range(0, 1) == 1) compute = 1'b0;
        end
        n = 0;
        while (!fin && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no finish after %0d cycles expected finish", n);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            compute = 1'b0;
            return;
        end
        stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            @(negedge clk);
            check("stall_finished", {31'd0, fin}, 32'd1);
            check("stall_result", res, exp_res);
        end
        stall   = 1'b0;
        compute = 1'b0;
        @(negedge clk);
        check("idle_after_release", {31'd0, fin}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          fin_seen;

        #12;
        check("reset_finished", {31'd0, fin}, 32'd0);
        check("reset_result", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'b01, 32'd100, 32'd7, 5, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(2'b01, 32'd5, 32'd0, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
                3: begin ra = $urandom; rb = -($urandom_range(1, 20)); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            do_op(ro, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Flush mid-calculation, then a fresh request on the very next cycle.
        compute = 1'b1;
        op      = 2'b01;
        opa     = 32'd1000;
        opb     = 32'd3;
        repeat (10) @(negedge clk);
        compute = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_no_finish", {31'd0, fin}, 32'd0);
        do_op(2'b11, 32'd1000, 32'd3, 0, 1'b0);

        // Asynchronous reset in the middle of a calculation.
        compute = 1'b1;
        op      = 2'b01;
        opa     = 32'd77777;
        opb     = 32'd13;
        repeat (10) @(negedge clk);
        compute = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_finished", {31'd0, fin}, 32'd0);
        check("async_reset_result", res, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        fin_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (fin) fin_seen++;
        end
        check("no_finish_after_reset", fin_seen, 32'd0);

        do_op(2'b00, 32'd12345, 32'hFFFF_FFF0, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
